// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the timer digit-entry block.
//   - press FSM state encoding
//   - BCD digit width and parameter defaults
//   - prio_key(): highest-set-switch encoder
package timer_pkg;

  localparam int BCD_W            = 4;
  localparam int MAX_SW           = 10;
  localparam int NUM_SW_DEF       = 10;
  localparam int NUM_DIGITS_DEF   = 4;
  localparam int DEBOUNCE_CYC_DEF = 4;
  // Wide enough for DEBOUNCE_CYC up to 255.
  localparam int DEB_CNT_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } press_state_t;

  // Highest set switch wins; the loop runs upward so later hits override.
  function automatic logic [BCD_W-1:0] prio_key(input logic [MAX_SW-1:0] sw);
    logic [BCD_W-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_SW; i++)
      if (sw[i]) k = BCD_W'(i);
    return k;
  endfunction

endpackage

// File: rtl/key_press_detector.sv
// key_press_detector: turns raw digit switches into one accept pulse per press.
//   clk       system clock
//   rst       synchronous active-low reset
//   switches  raw, unsynchronised switch levels
//   key       encoded digit of the press being debounced (valid with accept)
//   accept    one-cycle pulse when a press has been stable long enough
module key_press_detector
  import timer_pkg::*;
#(
  parameter int NUM_SW       = NUM_SW_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] switches,
  output logic [3:0]        key,
  output logic              accept
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYC - 1);

  logic [NUM_SW-1:0]    sync1, sync2, pat;
  logic [DEB_CNT_W-1:0] cnt;
  press_state_t         state;

  // Accept fires in the cycle the captured pattern has been seen DEBOUNCE_CYC
  // more times after capture; the FSM leaves DEBOUNCE on the same edge, so
  // it can only fire once per press.
  assign accept = (state == ST_DEBOUNCE) && (sync2 == pat) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      pat   <= '0;
      key   <= '0;
      cnt   <= '0;
      state <= ST_IDLE;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
      case (state)
        ST_IDLE: begin
          if (sync2 != '0) begin
            state <= ST_DEBOUNCE;
            cnt   <= '0;
            pat   <= sync2;
            key   <= prio_key(MAX_SW'(sync2));
          end
        end
        ST_DEBOUNCE: begin
          if (sync2 == '0) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (sync2 != pat) begin
            // New non-zero pattern: restart debounce on it.
            pat <= sync2;
            key <= prio_key(MAX_SW'(sync2));
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HELD: begin
          // cnt counts consecutive all-zero cycles; any bounce restarts it.
          if (sync2 != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/timer_digit_entry.sv
// timer_digit_entry: keypad-style BCD entry for a countdown timer.
//   clk          system clock
//   rst          synchronous active-low reset
//   switches     raw digit switches, index i enters digit i
//   enable       1 = accepted presses are shifted in
//   clear        1 = zero all digits and the count on the next edge
//   digits       packed BCD, digit k at [4k+3:4k] (digit 0 = units of seconds)
//   digit_count  digits entered since reset/clear, saturates at NUM_DIGITS
//   full         digit_count == NUM_DIGITS
//   key_strobe   one-cycle pulse after a digit has been shifted in
//   nonzero      any digit non-zero
//   sec_invalid  tens-of-seconds digit above 5
module timer_digit_entry
  import timer_pkg::*;
#(
  parameter int NUM_SW       = NUM_SW_DEF,
  parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_SW-1:0]                  switches,
  input  logic                               enable,
  input  logic                               clear,
  output logic [BCD_W*NUM_DIGITS-1:0]        digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_count,
  output logic                               full,
  output logic                               key_strobe,
  output logic                               nonzero,
  output logic                               sec_invalid
);

  localparam int                CNT_W    = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_DIGITS);

  logic [NUM_DIGITS-1:0][BCD_W-1:0] dig;
  logic [CNT_W-1:0]                 cnt;
  logic [3:0]                       key;
  logic                             accept;

  key_press_detector #(
    .NUM_SW       (NUM_SW),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_kpd (
    .clk      (clk),
    .rst      (rst),
    .switches (switches),
    .key      (key),
    .accept   (accept)
  );

  // clear has priority over a same-cycle accept; full blocks entry without
  // wrapping so the oldest digits are never lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dig        <= '0;
      cnt        <= '0;
      key_strobe <= 1'b0;
    end else if (clear) begin
      dig        <= '0;
      cnt        <= '0;
      key_strobe <= 1'b0;
    end else if (accept && enable && !full) begin
      dig        <= {dig[NUM_DIGITS-2:0], key};
      cnt        <= cnt + 1'b1;
      key_strobe <= 1'b1;
    end else begin
      key_strobe <= 1'b0;
    end
  end

  assign digits      = dig;
  assign digit_count = cnt;
  assign full        = (cnt == CNT_FULL);
  assign nonzero     = |dig;

  generate
    if (NUM_DIGITS >= 2) begin : g_sec
      assign sec_invalid = (dig[1] > 4'd5);
    end else begin : g_nosec
      assign sec_invalid = 1'b0;
    end
  endgenerate

endmodule

// File: doc/timer_digit_entry.md
TIMER_DIGIT_ENTRY -- requirements
Module: timer_digit_entry

Interface
REQ-001 Parameter NUM_SW, default 10, number of digit switches (legal 2..10); switch index i enters digit value i.
REQ-002 Parameter NUM_DIGITS, default 4, number of BCD timer digits held (legal 2..8); digit 0 = units of seconds, 1 = tens of seconds, 2 = units of minutes, 3 = tens of minutes.
REQ-003 Parameter DEBOUNCE_CYC, default 4, cycles a switch pattern must be stable before it is accepted (legal 1..255).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low; 0 resets all state at the next rising clk edge.
REQ-006 switches  input  NUM_SW  raw digit switches, level-sensitive, unsynchronised.
REQ-007 enable  input  1  1 = digit entry allowed; 0 = accepted presses are discarded.
REQ-008 clear  input  1  1 = zero all digits and the digit count at the next edge.
REQ-009 digits  output  4*NUM_DIGITS  packed BCD; digit k at bits [4k+3:4k].
REQ-010 digit_count  output  $clog2(NUM_DIGITS+1)  number of digits entered since reset/clear, saturating at NUM_DIGITS.
REQ-011 full  output  1  1 when digit_count == NUM_DIGITS.
REQ-012 key_strobe  output  1  one-cycle pulse in the cycle after a digit is shifted in.
REQ-013 nonzero  output  1  1 when any digit is non-zero.
REQ-014 sec_invalid  output  1  1 when NUM_DIGITS >= 2 and digit 1 (tens of seconds) > 5.

Function
REQ-015 switches SHALL pass through a 2-flop synchroniser before any other use.
REQ-016 Encoded key SHALL be the index of the highest set synchronised switch (priority to highest index).
REQ-017 Press FSM SHALL have states IDLE, DEBOUNCE, HELD.
REQ-018 IDLE -> DEBOUNCE when synchronised switches != 0; debounce counter loads 0 and the pattern is captured.
REQ-019 DEBOUNCE: counter increments each cycle the pattern equals the captured pattern; a differing non-zero pattern recaptures and restarts the count; all-zero returns to IDLE.
REQ-020 DEBOUNCE -> HELD when the counter reaches DEBOUNCE_CYC-1; that cycle is the accept event for the captured pattern's encoded key.
REQ-021 HELD -> IDLE only when synchronised switches == 0 for DEBOUNCE_CYC consecutive cycles; no further accept event while in HELD (one digit per press).
REQ-022 On accept with enable=1, full=0, clear=0: digit[k] <= digit[k-1] for k = NUM_DIGITS-1 down to 1; digit[0] <= key; digit_count increments; key_strobe = 1 next cycle.
REQ-023 On accept with full=1: digits and count unchanged (non-recycling, no wrap); key_strobe stays 0.
REQ-024 On accept with enable=0: press discarded; FSM still goes to HELD.
REQ-025 clear=1 SHALL zero digits and digit_count in the same edge regardless of FSM state; a simultaneous accept is discarded; FSM state is unaffected.
REQ-026 Latency: stable switch edge to digits update = 2 (sync) + DEBOUNCE_CYC cycles; key_strobe one cycle later.
REQ-027 full, nonzero and sec_invalid SHALL be combinational decodes of registered state.

Reset
REQ-028 While rst=0 at a clk edge: digits = 0, digit_count = 0, key_strobe = 0, FSM = IDLE, debounce counter = 0, synchroniser flops = 0.
REQ-029 Reset mid-press SHALL leave FSM in IDLE; a switch still held after reset SHALL be accepted as a new press once debounced.

Structure
REQ-030 Shared package timer_pkg SHALL hold the press-FSM state encoding, the BCD digit width constant (4) and the parameter defaults.
REQ-031 Synchroniser, priority encoder and press FSM SHALL be one sub-module, key_press_detector, outputting key[3:0] and an accept pulse; timer_digit_entry holds the shift register and counters.

Verification
REQ-032 NUM_DIGITS=4, press 1,2,3,0 (each held 10 cycles, released 10) -> digits=16'h1230, digit_count=4, full=1, four key_strobe pulses.
REQ-033 After REQ-032, press 7 -> digits stay 16'h1230, no key_strobe.
REQ-034 Switch glitch of 2 cycles with DEBOUNCE_CYC=4 -> no digit entered; switches 3 and 8 pressed together -> digit 8 entered once.
REQ-035 clear asserted in the accept cycle of key 5 -> digits=0, digit_count=0, no key_strobe; press 6 later -> digits=16'h0006, count=1.
REQ-036 Enter 9,0 -> sec_invalid=1, nonzero=1; rst=0 while key held -> all outputs 0, key re-accepted after release-free debounce.
